// File: rtl/ff_check_monitor.sv
// rtl/ff_check_monitor.sv - compares a flip-flop under test against a golden model over a run of samples.
// Optional FFCHK_COMPL_CHECK_EN also flags qbar_dut that is not the complement of q_dut.
module ff_check_monitor #(
    parameter int VEC_COUNT = 20,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample,
    input  logic             q_dut,
    input  logic             qbar_dut,
    input  logic             q_ref,
    input  logic             qbar_ref,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             err
);

    // The index is widened when a run is longer than the counters can express.
    localparam int IDX_W = ($clog2(VEC_COUNT) > CNT_W) ? $clog2(VEC_COUNT) : CNT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);
    localparam logic [CNT_W-1:0] ONES     = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] first_fail_q, first_fail_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             mismatch;
    logic             compl_ok;

    // Unknown inputs make the equality test non-true, so they fall into the mismatch path.
    always_comb begin
        mismatch = 1'b1;
        compl_ok = 1'b0;
        if ((q_dut == q_ref) && (qbar_dut == qbar_ref)) begin
            mismatch = 1'b0;
        end
        if (qbar_dut != q_dut) begin
            compl_ok = 1'b1;
        end
`ifdef FFCHK_COMPL_CHECK_EN
        mismatch = mismatch | ~compl_ok;
`endif
    end

    always_comb begin
        state_d      = state_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        idx_d        = idx_q;
        err_d        = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    pass_cnt_d   = '0;
                    fail_cnt_d   = '0;
                    first_fail_d = ONES;
                    idx_d        = '0;
                    err_d        = 1'b0;
                end
            end
            RUN: begin
                if (sample) begin
                    if (mismatch) begin
                        if (fail_cnt_q != ONES) begin
                            fail_cnt_d = fail_cnt_q + 1'b1;
                        end
                        if (!err_q) begin
                            first_fail_d = (idx_q > IDX_W'(ONES)) ? ONES : CNT_W'(idx_q);
                        end
                        err_d = 1'b1;
                    end else if (pass_cnt_q != ONES) begin
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= ONES;
            idx_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
        end
    end

    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_idx = first_fail_q;
    assign err            = err_q;

endmodule

// File: tb/tb_ff_check_monitor.sv
// tb/tb_ff_check_monitor.sv - directed table-driven bench for ff_check_monitor.
module tb_ff_check_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, sample = 1'b0;
    logic q_dut = 1'b0, qbar_dut = 1'b1, q_ref = 1'b0, qbar_ref = 1'b1;
    logic busy, done, err;
    logic [7:0] pass_cnt, fail_cnt, first_fail_idx;

    logic b_start = 1'b0, b_sample = 1'b0;
    logic b_busy, b_done, b_err;
    logic [7:0] b_pass, b_fail, b_ffi;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ff_check_monitor u_dut (
        .clk(clk), .rst(rst), .start(start), .sample(sample),
        .q_dut(q_dut), .qbar_dut(qbar_dut), .q_ref(q_ref), .qbar_ref(qbar_ref),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .err(err)
    );

    ff_check_monitor #(.VEC_COUNT(300), .CNT_W(8)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .sample(b_sample),
        .q_dut(1'b1), .qbar_dut(1'b0), .q_ref(1'b0), .qbar_ref(1'b1),
        .busy(b_busy), .done(b_done), .pass_cnt(b_pass), .fail_cnt(b_fail),
        .first_fail_idx(b_ffi), .err(b_err)
    );

    typedef struct {
        logic  st, smp, qd, qbd, qr, qbr;
        logic  e_busy, e_done, e_err;
        int    e_pass, e_fail, e_ffi;
        string name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic st, logic smp, logic qd, logic qr,
                                logic e_busy, logic e_done, int e_pass, int e_fail,
                                int e_ffi, logic e_err);
        vec_t v;
        v.name = nm; v.st = st; v.smp = smp;
        v.qd = qd; v.qbd = ~qd; v.qr = qr; v.qbr = ~qr;
        v.e_busy = e_busy; v.e_done = e_done; v.e_pass = e_pass;
        v.e_fail = e_fail; v.e_ffi = e_ffi; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(string nm, logic e_busy, logic e_done, int e_pass,
                           int e_fail, int e_ffi, logic e_err);
        chk({nm, ".busy"}, int'(busy), int'(e_busy));
        chk({nm, ".done"}, int'(done), int'(e_done));
        chk({nm, ".pass_cnt"}, int'(pass_cnt), e_pass);
        chk({nm, ".fail_cnt"}, int'(fail_cnt), e_fail);
        chk({nm, ".first_fail_idx"}, int'(first_fail_idx), e_ffi);
        chk({nm, ".err"}, int'(err), int'(e_err));
    endtask

    // Drive at the current (negedge) time, settle 1 time unit past the rising edge.
    task automatic tick(logic st, logic smp, logic qd, logic qbd, logic qr, logic qbr);
        start = st; sample = smp; q_dut = qd; qbar_dut = qbd; q_ref = qr; qbar_ref = qbr;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(vec_t v);
        tick(v.st, v.smp, v.qd, v.qbd, v.qr, v.qbr);
        chk_all(v.name, v.e_busy, v.e_done, v.e_pass, v.e_fail, v.e_ffi, v.e_err);
        @(negedge clk);
    endtask

    initial begin
        int nf;
        int exp_compl;

        // Idle sample ignored, start, clean run with an ignored start mid-run.
        tbl.push_back(mk("idle_sample", 0, 1, 1, 0, 0, 0, 0, 0, 255, 0));
        tbl.push_back(mk("start1", 1, 0, 0, 0, 1, 0, 0, 0, 255, 0));
        for (int k = 0; k < 20; k++) begin
            tbl.push_back(mk($sformatf("clean%0d", k), (k == 5), 1, k[0], k[0],
                             (k < 19), (k == 19), k + 1, 0, 255, 0));
            if (k == 9)
                tbl.push_back(mk("run_start_nosmp", 1, 0, 0, 0, 1, 0, 10, 0, 255, 0));
        end
        tbl.push_back(mk("done_hold", 0, 1, 1, 0, 0, 1, 20, 0, 255, 0));
        tbl.push_back(mk("start_in_done", 1, 0, 0, 0, 1, 0, 0, 0, 255, 0));
        for (int k = 0; k < 20; k++) begin
            nf = (k >= 3 ? 1 : 0) + (k >= 11 ? 1 : 0);
            tbl.push_back(mk($sformatf("inv%0d", k), 0, 1,
                             (k == 3 || k == 11) ? 1'b1 : 1'b0, 1'b0,
                             (k < 19), (k == 19), k + 1 - nf, nf,
                             (k >= 3) ? 3 : 255, (k >= 3)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 255, 0);
        chk("big_reset.fail_cnt", int'(b_fail), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset mid-run discards partial results.
        tick(1, 0, 0, 1, 0, 1);
        for (int k = 0; k < 8; k++) tick(0, 1, 1, 0, 1, 0);
        chk_all("pre_abort", 1, 0, 8, 0, 255, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("abort", 0, 0, 0, 0, 255, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(0, 1, 1, 0, 0, 1);
        chk_all("post_abort_idle", 0, 0, 0, 0, 255, 0);
        @(negedge clk);
        tick(1, 0, 0, 1, 0, 1);
        for (int k = 0; k < 20; k++) tick(0, 1, 0, 1, 0, 1);
        chk_all("rerun", 0, 1, 20, 0, 255, 0);
        @(negedge clk);

        // Complement violation while agreeing with the reference.
`ifdef FFCHK_COMPL_CHECK_EN
        exp_compl = 1;
`else
        exp_compl = 0;
`endif
        tick(1, 0, 0, 1, 0, 1);
        tick(0, 1, 1, 1, 1, 1);
        chk("compl.fail_cnt", int'(fail_cnt), exp_compl);
        chk("compl.pass_cnt", int'(pass_cnt), 1 - exp_compl);
        @(negedge clk);

        // Long run with every sample failing: fail_cnt saturates.
        b_start = 1'b1;
        @(posedge clk); #1;
        chk("big_start.busy", int'(b_busy), 1);
        @(negedge clk);
        b_start = 1'b0;
        b_sample = 1'b1;
        repeat (299) @(posedge clk);
        #1;
        chk("big_299.busy", int'(b_busy), 1);
        chk("big_299.done", int'(b_done), 0);
        chk("big_299.fail_cnt", int'(b_fail), 255);
        @(posedge clk);
        #1;
        b_sample = 1'b0;
        chk("big_300.done", int'(b_done), 1);
        chk("big_300.busy", int'(b_busy), 0);
        chk("big_300.fail_cnt", int'(b_fail), 255);
        chk("big_300.pass_cnt", int'(b_pass), 0);
        chk("big_300.first_fail_idx", int'(b_ffi), 0);
        chk("big_300.err", int'(b_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
